l2_req_sched: RTL and testbench

L2_REQ_SCHED -- requirements
Module: l2_req_sched

---
 rtl/l2_req_sched.sv | 161 ++++++++++++++++
 tb/tb_l2_req_sched.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_req_sched.sv
// l2_req_sched: round-robin L2 URAM read-issue scheduler with a credit limit on
// outstanding reads and per-stream completion counters feeding response handshakes.
// Optional statistics outputs (o_stat_issued, o_stat_stall) are built only when
// the macro L2_REQ_SCHED_STATS_EN is defined.
module l2_req_sched #(
   parameter int nstrms    = 64,
   parameter int sid_width = $clog2(nstrms),
   parameter int maxout    = 4,
   parameter int cnt_width = $clog2(maxout + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [nstrms-1:0]    i_req_v,
   output logic [nstrms-1:0]    i_req_r,
   output logic                 o_rd_v,
   input  logic                 o_rd_r,
   output logic [sid_width-1:0] o_rd_sid,
   input  logic                 i_done_v,
   output logic                 i_done_r,
   input  logic [sid_width-1:0] i_done_sid,
   output logic [nstrms-1:0]    o_rsp_v,
   input  logic [nstrms-1:0]    o_rsp_r
`ifdef L2_REQ_SCHED_STATS_EN
   ,
   output logic [31:0]          o_stat_issued,
   output logic [31:0]          o_stat_stall
`endif
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam logic [cnt_width-1:0] max_credit = cnt_width'(maxout);

   state_t               state;
   state_t               state_nxt;
   logic [sid_width-1:0] ptr;
   logic [sid_width-1:0] sid_q;
   logic [sid_width-1:0] grant_sid;
   logic [cnt_width-1:0] credit;
   logic [cnt_width-1:0] pend [nstrms];
   logic [nstrms-1:0]    done_hit;
   logic [nstrms-1:0]    rsp_fire;
   logic                 done_xfer;
   logic                 slot_free;
   logic                 credit_ok;
   logic                 found;
   logic                 grant;

   // A completion with no read outstanding is a protocol error and is dropped.
   assign i_done_r  = reset;
   assign done_xfer = i_done_v && reset && (credit != '0);
   assign slot_free = (state == IDLE) || o_rd_r;
   assign credit_ok = (credit < max_credit) || done_xfer;
   assign grant     = reset && slot_free && credit_ok && found;
   assign o_rd_v    = (state == HOLD);
   assign o_rd_sid  = sid_q;
   assign rsp_fire  = o_rsp_v & o_rsp_r;

   // Round-robin search: first requesting stream at or above ptr, wrapping.
   always_comb begin
      int idx;
      found     = 1'b0;
      grant_sid = '0;
      idx       = 0;
      for (int k = 0; k < nstrms; k++) begin
         idx = int'(ptr) + k;
         if (idx >= nstrms) idx = idx - nstrms;
         if (!found && i_req_v[sid_width'(idx)]) begin
            found     = 1'b1;
            grant_sid = sid_width'(idx);
         end
      end
   end

   // Grant is a single-cycle one-hot ready pulse to the winning stream.
   always_comb begin
      i_req_r = '0;
      if (grant) i_req_r[grant_sid] = 1'b1;
   end

   // Issue FSM next state: a new grant keeps HOLD, an accepted read without one frees the slot.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant) state_nxt = HOLD;
         HOLD:    if (o_rd_r && !grant) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Issue state, held stream id and round-robin pointer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         sid_q <= '0;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         if (grant) begin
            sid_q <= grant_sid;
            ptr   <= (grant_sid == sid_width'(nstrms - 1)) ? '0 : grant_sid + sid_width'(1);
         end
      end
   end

   // Credit tracks reads granted but not yet completed; grant and done together cancel.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         credit <= '0;
      end else if (grant && !done_xfer) begin
         credit <= credit + cnt_width'(1);
      end else if (done_xfer && !grant) begin
         credit <= credit - cnt_width'(1);
      end
   end

   // Decode which stream the accepted completion belongs to.
   always_comb begin
      done_hit = '0;
      if (done_xfer) done_hit[i_done_sid] = 1'b1;
   end

   // Per-stream count of lines delivered to L1 but not yet handed to the consumer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < nstrms; s++) pend[s] <= '0;
      end else begin
         for (int s = 0; s < nstrms; s++) begin
            case ({done_hit[s], rsp_fire[s]})
               2'b10:   pend[s] <= pend[s] + cnt_width'(1);
               2'b01:   pend[s] <= pend[s] - cnt_width'(1);
               default: pend[s] <= pend[s];
            endcase
         end
      end
   end

   // A stream has a response to offer whenever it has any delivered line pending.
   always_comb begin
      for (int s = 0; s < nstrms; s++) o_rsp_v[s] = (pend[s] != '0);
   end

`ifdef L2_REQ_SCHED_STATS_EN
   // Saturating counts of accepted reads and of request cycles blocked on full credit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_stat_issued <= '0;
         o_stat_stall  <= '0;
      end else begin
         if (o_rd_v && o_rd_r && (o_stat_issued != '1))
            o_stat_issued <= o_stat_issued + 32'd1;
         if ((|i_req_v) && (credit == max_credit) && (o_stat_stall != '1))
            o_stat_stall <= o_stat_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_l2_req_sched.sv
// Testbench for l2_req_sched: directed scenarios plus a randomized run checked
// against a queue-free behavioural model of the scheduling rules.
module tb_l2_req_sched;

   localparam int N      = 64;
   localparam int SW     = 6;
   localparam int MAXOUT = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  i_req_v;
   logic [N-1:0]  i_req_r;
   logic          o_rd_v;
   logic          o_rd_r;
   logic [SW-1:0] o_rd_sid;
   logic          i_done_v;
   logic          i_done_r;
   logic [SW-1:0] i_done_sid;
   logic [N-1:0]  o_rsp_v;
   logic [N-1:0]  o_rsp_r;
`ifdef L2_REQ_SCHED_STATS_EN
   logic [31:0]   o_stat_issued;
   logic [31:0]   o_stat_stall;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   // Behavioural model state: read slot occupancy, outstanding reads, pointer, pending lines.
   bit           m_hold;
   int           m_sid;
   int           m_p;
   int           m_credit;
   int           m_pend [N];
   int           m_issued;
   int           m_stall;
   int           m_grant;
   bit           m_done_fire;
   logic [N-1:0] exp_req_r;
   logic [N-1:0] exp_rsp_v;

   always #5 clk = ~clk;

   l2_req_sched dut (
      .clk        (clk),
      .reset      (reset),
      .i_req_v    (i_req_v),
      .i_req_r    (i_req_r),
      .o_rd_v     (o_rd_v),
      .o_rd_r     (o_rd_r),
      .o_rd_sid   (o_rd_sid),
      .i_done_v   (i_done_v),
      .i_done_r   (i_done_r),
      .i_done_sid (i_done_sid),
      .o_rsp_v    (o_rsp_v),
      .o_rsp_r    (o_rsp_r)
`ifdef L2_REQ_SCHED_STATS_EN
      ,
      .o_stat_issued (o_stat_issued),
      .o_stat_stall  (o_stat_stall)
`endif
   );

   task automatic model_reset();
      m_hold   = 1'b0;
      m_sid    = 0;
      m_p      = 0;
      m_credit = 0;
      m_issued = 0;
      m_stall  = 0;
      for (int s = 0; s < N; s++) m_pend[s] = 0;
   endtask

   // Expected combinational behaviour for the current inputs.
   task automatic model_eval();
      bit slot;
      bit room;
      int s;
      m_done_fire = i_done_v && (m_credit > 0);
      slot        = !m_hold || o_rd_r;
      room        = (m_credit < MAXOUT) || m_done_fire;
      m_grant     = -1;
      if (slot && room) begin
         for (int k = 0; k < N; k++) begin
            s = (m_p + k) % N;
            if (m_grant < 0 && i_req_v[SW'(s)]) m_grant = s;
         end
      end
      exp_req_r = '0;
      if (m_grant >= 0) exp_req_r[SW'(m_grant)] = 1'b1;
      for (int j = 0; j < N; j++) exp_rsp_v[j] = (m_pend[j] > 0);
   endtask

   // Advance the model by one clock edge.
   task automatic model_commit();
      if (m_hold && o_rd_r) m_issued++;
      if ((|i_req_v) && m_credit == MAXOUT) m_stall++;
      for (int s = 0; s < N; s++) if (exp_rsp_v[s] && o_rsp_r[s]) m_pend[s]--;
      if (m_done_fire) begin
         m_pend[i_done_sid]++;
         m_credit--;
      end
      if (m_grant >= 0) begin
         m_credit++;
         m_hold = 1'b1;
         m_sid  = m_grant;
         m_p    = (m_grant + 1) % N;
      end else if (m_hold && o_rd_r) begin
         m_hold = 1'b0;
      end
   endtask

   task automatic cycle();
      model_eval();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic zero_inputs();
      i_req_v    = '0;
      o_rd_r     = 1'b0;
      i_done_v   = 1'b0;
      i_done_sid = '0;
      o_rsp_r    = '0;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      zero_inputs();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset    = 1'b0;
      i_req_v  = '1;
      i_done_v = 1'b1;
      o_rd_r   = 1'b1;
      o_rsp_r  = '1;
      #3;
      tests_run++;
      if (o_rd_v !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rd_v: got %b want 0", o_rd_v); end
      tests_run++;
      if (o_rd_sid !== '0) begin tests_failed++; $display("[TB] FAIL reset_rd_sid: got %0d want 0", o_rd_sid); end
      tests_run++;
      if (i_req_r !== '0) begin tests_failed++; $display("[TB] FAIL reset_req_r: got %h want 0", i_req_r); end
      tests_run++;
      if (i_done_r !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done_r: got %b want 0", i_done_r); end
      tests_run++;
      if (o_rsp_v !== '0) begin tests_failed++; $display("[TB] FAIL reset_rsp_v: got %h want 0", o_rsp_v); end
      @(posedge clk);
      #1;
      tests_run++;
      if (o_rd_v !== 1'b0 || i_req_r !== '0) begin
         tests_failed++;
         $display("[TB] FAIL reset_edge: got rd_v=%b req_r=%h want 0/0", o_rd_v, i_req_r);
      end
      apply_reset();
      tests_run++;
      if (i_done_r !== 1'b1) begin tests_failed++; $display("[TB] FAIL done_r_after_reset: got %b want 1", i_done_r); end
   endtask

   task automatic test_round_robin();
      int seq [3];
      seq = '{3, 7, 60};
      apply_reset();
      i_req_v[3]  = 1'b1;
      i_req_v[7]  = 1'b1;
      i_req_v[60] = 1'b1;
      o_rd_r      = 1'b1;
      o_rsp_r     = '1;
      i_done_v    = 1'b1;
      i_done_sid  = SW'(3);
      for (int k = 0; k < 9; k++) begin
         #2;
         tests_run++;
         if (i_req_r !== (64'd1 << seq[k % 3])) begin
            tests_failed++;
            $display("[TB] FAIL rr_req_r[%0d]: got %h want stream %0d", k, i_req_r, seq[k % 3]);
         end
         if (k > 0) begin
            tests_run++;
            if (o_rd_v !== 1'b1 || o_rd_sid !== SW'(seq[(k - 1) % 3])) begin
               tests_failed++;
               $display("[TB] FAIL rr_rd_sid[%0d]: got v=%b sid=%0d want 1/%0d", k, o_rd_v, o_rd_sid, seq[(k - 1) % 3]);
            end
         end
         cycle();
      end
      zero_inputs();
   endtask

   task automatic test_credit_limit();
      int grants;
      apply_reset();
      i_req_v[0]  = 1'b1;
      i_req_v[1]  = 1'b1;
      i_req_v[2]  = 1'b1;
      i_req_v[10] = 1'b1;
      i_req_v[20] = 1'b1;
      i_req_v[30] = 1'b1;
      o_rd_r      = 1'b1;
      o_rsp_r     = '1;
      grants      = 0;
      for (int k = 0; k < 8; k++) begin
         #2;
         if (i_req_r != '0) grants++;
         cycle();
      end
      tests_run++;
      if (grants != 4) begin tests_failed++; $display("[TB] FAIL credit_grants: got %0d want 4", grants); end
      #2;
      tests_run++;
      if (i_req_r !== '0 || o_rd_v !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL credit_full: got req_r=%h rd_v=%b want 0/0", i_req_r, o_rd_v);
      end
      i_done_v   = 1'b1;
      i_done_sid = SW'(0);
      #1;
      tests_run++;
      if (i_req_r !== (64'd1 << 20)) begin
         tests_failed++;
         $display("[TB] FAIL credit_done_grant: got %h want stream 20", i_req_r);
      end
      cycle();
      zero_inputs();
   endtask

   task automatic test_hold_stall();
      int grants;
      apply_reset();
      i_req_v[9] = 1'b1;
      o_rsp_r    = '1;
      #2;
      tests_run++;
      if (i_req_r !== (64'd1 << 9)) begin tests_failed++; $display("[TB] FAIL stall_first_grant: got %h want stream 9", i_req_r); end
      cycle();
      for (int k = 0; k < 5; k++) begin
         #2;
         tests_run++;
         if (o_rd_v !== 1'b1 || o_rd_sid !== SW'(9) || i_req_r !== '0) begin
            tests_failed++;
            $display("[TB] FAIL stall_hold[%0d]: got v=%b sid=%0d req_r=%h want 1/9/0", k, o_rd_v, o_rd_sid, i_req_r);
         end
         cycle();
      end
      o_rd_r = 1'b1;
      grants = 0;
      for (int k = 0; k < 8; k++) begin
         #2;
         if (i_req_r != '0) grants++;
         cycle();
      end
      tests_run++;
      if (grants != 3) begin tests_failed++; $display("[TB] FAIL stall_credit: got %0d more grants want 3", grants); end
      zero_inputs();
   endtask

   task automatic test_pend_rsp();
      int grants;
      apply_reset();
      i_req_v[5] = 1'b1;
      o_rd_r     = 1'b1;
      for (int k = 0; k < 2; k++) begin
         #2;
         cycle();
      end
      i_req_v    = '0;
      i_done_v   = 1'b1;
      i_done_sid = SW'(5);
      for (int k = 0; k < 2; k++) begin
         #2;
         cycle();
      end
      i_done_v = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #2;
         tests_run++;
         if (o_rsp_v !== (64'd1 << 5)) begin tests_failed++; $display("[TB] FAIL pend_hold[%0d]: got %h want stream 5", k, o_rsp_v); end
         cycle();
      end
      o_rsp_r[5] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #2;
         tests_run++;
         if (o_rsp_v[5] !== (k < 2)) begin tests_failed++; $display("[TB] FAIL pend_drain[%0d]: got %b want %b", k, o_rsp_v[5], (k < 2)); end
         cycle();
      end
      i_done_v   = 1'b1;
      i_done_sid = SW'(7);
      #2;
      cycle();
      i_done_v = 1'b0;
      #2;
      tests_run++;
      if (o_rsp_v !== '0) begin tests_failed++; $display("[TB] FAIL stray_done_pend: got %h want 0", o_rsp_v); end
      i_req_v[1] = 1'b1;
      grants     = 0;
      for (int k = 0; k < 6; k++) begin
         #2;
         if (i_req_r != '0) grants++;
         cycle();
      end
      tests_run++;
      if (grants != 4) begin tests_failed++; $display("[TB] FAIL stray_done_credit: got %0d grants want 4", grants); end
      zero_inputs();
   endtask

   task automatic test_reset_mid_hold();
      int grants;
      apply_reset();
      i_req_v[10] = 1'b1;
      i_req_v[11] = 1'b1;
      i_req_v[12] = 1'b1;
      o_rd_r      = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #2;
         cycle();
      end
      i_req_v = '0;
      o_rd_r  = 1'b0;
      #2;
      tests_run++;
      if (o_rd_v !== 1'b1 || o_rd_sid !== SW'(12)) begin
         tests_failed++;
         $display("[TB] FAIL midhold_pre: got v=%b sid=%0d want 1/12", o_rd_v, o_rd_sid);
      end
      reset = 1'b0;
      #1;
      tests_run++;
      if (o_rd_v !== 1'b0 || o_rd_sid !== '0 || i_done_r !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL midhold_async: got v=%b sid=%0d done_r=%b want 0/0/0", o_rd_v, o_rd_sid, i_done_r);
      end
      i_req_v = '1;
      o_rd_r  = 1'b1;
      @(posedge clk);
      #3;
      reset = 1'b1;
      model_reset();
      #1;
      tests_run++;
      if (i_req_r !== 64'd1) begin tests_failed++; $display("[TB] FAIL midhold_first_grant: got %h want stream 0", i_req_r); end
      grants = (i_req_r != '0) ? 1 : 0;
      cycle();
      for (int k = 0; k < 6; k++) begin
         #2;
         if (i_req_r != '0) grants++;
         cycle();
      end
      tests_run++;
      if (grants != 4) begin tests_failed++; $display("[TB] FAIL midhold_credit: got %0d grants want 4", grants); end
      zero_inputs();
   endtask

`ifdef L2_REQ_SCHED_STATS_EN
   task automatic test_stats();
      apply_reset();
      tests_run++;
      if (o_stat_issued !== 32'd0 || o_stat_stall !== 32'd0) begin
         tests_failed++;
         $display("[TB] FAIL stats_reset: got %0d/%0d want 0/0", o_stat_issued, o_stat_stall);
      end
      i_req_v[1] = 1'b1;
      o_rd_r     = 1'b1;
      o_rsp_r    = '1;
      i_done_sid = SW'(1);
      for (int k = 0; k < 17; k++) begin
         i_done_v = (k >= 1 && k <= 6);
         #2;
         cycle();
      end
      i_req_v  = '0;
      i_done_v = 1'b0;
      #2;
      tests_run++;
      if (o_stat_issued !== 32'd10) begin tests_failed++; $display("[TB] FAIL stats_issued: got %0d want 10", o_stat_issued); end
      tests_run++;
      if (o_stat_stall !== 32'd7) begin tests_failed++; $display("[TB] FAIL stats_stall: got %0d want 7", o_stat_stall); end
      cycle();
      zero_inputs();
   endtask
`endif

   task automatic test_random();
      apply_reset();
      for (int c = 0; c < 3000; c++) begin
         i_req_v = {$urandom, $urandom} & {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) i_req_v = '0;
         o_rd_r     = ($urandom_range(0, 2) != 0);
         i_done_v   = $urandom_range(0, 1) != 0;
         i_done_sid = SW'($urandom_range(0, 7) * 9);
         o_rsp_r    = ~({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
         #2;
         model_eval();
         tests_run++;
         if (i_req_r !== exp_req_r) begin tests_failed++; $display("[TB] FAIL rand_req_r[%0d]: got %h want %h", c, i_req_r, exp_req_r); end
         tests_run++;
         if (o_rd_v !== m_hold) begin tests_failed++; $display("[TB] FAIL rand_rd_v[%0d]: got %b want %b", c, o_rd_v, m_hold); end
         if (m_hold) begin
            tests_run++;
            if (o_rd_sid !== SW'(m_sid)) begin tests_failed++; $display("[TB] FAIL rand_rd_sid[%0d]: got %0d want %0d", c, o_rd_sid, m_sid); end
         end
         tests_run++;
         if (o_rsp_v !== exp_rsp_v) begin tests_failed++; $display("[TB] FAIL rand_rsp_v[%0d]: got %h want %h", c, o_rsp_v, exp_rsp_v); end
         tests_run++;
         if (i_done_r !== 1'b1) begin tests_failed++; $display("[TB] FAIL rand_done_r[%0d]: got %b want 1", c, i_done_r); end
         cycle();
         if (tests_failed > 20) break;
      end
`ifdef L2_REQ_SCHED_STATS_EN
      #2;
      tests_run++;
      if (o_stat_issued !== 32'(m_issued) || o_stat_stall !== 32'(m_stall)) begin
         tests_failed++;
         $display("[TB] FAIL rand_stats: got %0d/%0d want %0d/%0d", o_stat_issued, o_stat_stall, m_issued, m_stall);
      end
`endif
      zero_inputs();
   endtask

   initial begin
      reset = 1'b0;
      zero_inputs();
      model_reset();
      test_reset();
      test_round_robin();
      test_credit_limit();
      test_hold_stall();
      test_pend_rsp();
      test_reset_mid_hold();
`ifdef L2_REQ_SCHED_STATS_EN
      test_stats();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
